// File: rtl/latch_ram_pkg.sv
// latch_ram_pkg: shared size encodings, controller states and access-size decode for the latch RAM
package latch_ram_pkg;
   localparam logic [1:0] SIZE_8  = 2'b00;
   localparam logic [1:0] SIZE_16 = 2'b01;
   localparam logic [1:0] SIZE_32 = 2'b10;
   localparam logic [1:0] NO_TXN  = 2'b11;

   typedef enum logic [1:0] {INIT, IDLE, BEAT, DONE} state_t;

   function automatic logic [2:0] nbytes_of(input logic [1:0] code);
      return code == SIZE_8 ? 3'd1 : code == SIZE_16 ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/latch_ram_ctrl_if.sv
// latch_ram_ctrl_if: TinyQV peripheral data-port bundle between the core and the latch RAM
interface latch_ram_ctrl_if #(
   parameter int ADDR_BITS = 6
);
   logic [ADDR_BITS-1:0] addr_in;
   logic [31:0]          data_in;
   logic [1:0]           data_write_n;
   logic [1:0]           data_read_n;
   logic [31:0]          data_out;
   logic                 data_ready;
   logic                 busy;

   modport master (output addr_in, data_in, data_write_n, data_read_n, input data_out, data_ready, busy);
   modport slave (input addr_in, data_in, data_write_n, data_read_n, output data_out, data_ready, busy);
endinterface

// File: rtl/latch_byte_bank.sv
// latch_byte_bank: one latch cell per RAM byte, fed by shared per-lane write buses, with per-lane read muxes
module latch_byte_bank #(
   parameter int RAM_BYTES  = 64,
   parameter int ADDR_BITS  = 6,
   parameter int LANE_BYTES = 1
) (
   input  logic                    clk,
   input  logic [ADDR_BITS-1:0]    base_i,
   input  logic [3:0]              we_i,
   input  logic [31:0]             wdata_i,
   output logic [8*LANE_BYTES-1:0] rdata_o
);
   logic [7:0] mem [RAM_BYTES];

   for (genvar i = 0; i < RAM_BYTES; i++) begin : g_cell
      logic [ADDR_BITS-1:0] lane;
      assign lane = ADDR_BITS'(i) - base_i;
      latch_reg_n #(.WIDTH(8)) u_cell (
         .clk    (clk),
         .wen_i  (lane < ADDR_BITS'(LANE_BYTES) && we_i[lane[1:0]]),
         .data_i (wdata_i[{lane[1:0], 3'b000} +: 8]),
         .data_o (mem[i])
      );
   end

   for (genvar l = 0; l < LANE_BYTES; l++) begin : g_rd
      assign rdata_o[8*l +: 8] = mem[base_i + ADDR_BITS'(l)];
   end
endmodule

// File: rtl/latch_reg_n.sv
// latch_reg_n: level-sensitive storage cell, transparent while clk is low and the write enable is high
module latch_reg_n #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             wen_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);
   // Open only in the low phase so the value settled just before the rising edge is the one kept
   always_latch begin
      if (wen_i && !clk) data_o <= data_i;
   end
endmodule

// File: rtl/latch_ram_ctrl.sv
// latch_ram_ctrl: multi-lane latch scratch RAM on the TinyQV data bus; define LATCH_RAM_ZERO_INIT_EN to zero the RAM after reset
module latch_ram_ctrl
   import latch_ram_pkg::*;
#(
   parameter int RAM_BYTES  = 64,
   parameter int ADDR_BITS  = 6,
   parameter int LANE_BYTES = 1
) (
   input logic             clk,
   input logic             rst,
   latch_ram_ctrl_if.slave bus
);
   localparam int LB = LANE_BYTES == 4 ? 2 : LANE_BYTES == 2 ? 1 : 0;
`ifdef LATCH_RAM_ZERO_INIT_EN
   localparam int INIT_LAST = RAM_BYTES / LANE_BYTES - 1;
`endif

   state_t                  state_q;
   logic [ADDR_BITS-1:0]    k_q, off, base;
   logic [31:0]             data_out_q, data_out_d, wdata;
   logic                    ready_q, exec, last, is_read, init_we, lane_on;
   logic [1:0]              txn_n, bi;
   logic [2:0]              nbytes, beats;
   logic [3:0]              we;
   logic [8*LANE_BYTES-1:0] rdata;

   assign txn_n   = bus.data_read_n & bus.data_write_n;
   assign is_read = bus.data_read_n != NO_TXN;
   assign nbytes  = nbytes_of(txn_n);
   assign beats   = (nbytes + 3'(LANE_BYTES - 1)) >> LB;
   assign exec    = !rst && txn_n != NO_TXN && (state_q == IDLE || state_q == BEAT);
   assign last    = k_q == ADDR_BITS'(beats - 3'd1);
   assign off     = k_q << LB;
`ifdef LATCH_RAM_ZERO_INIT_EN
   assign init_we = !rst && state_q == INIT;
`else
   assign init_we = 1'b0;
`endif
   assign base    = init_we ? off : bus.addr_in + off;

   // Lane enables, write-bus data and read capture for the beat running this cycle
   always_comb begin
      we         = '0;
      wdata      = '0;
      bi         = '0;
      lane_on    = 1'b0;
      data_out_d = data_out_q;
      for (int j = 0; j < 4; j++)
         if (exec && is_read && state_q == IDLE && j >= int'(nbytes)) data_out_d[8*j +: 8] = 8'h00;
      for (int l = 0; l < LANE_BYTES; l++) begin
         bi                = 2'(off + ADDR_BITS'(l));
         lane_on           = exec && int'(off) + l < int'(nbytes);
         we[l]             = init_we || (lane_on && !is_read);
         wdata[8*l +: 8]   = init_we ? 8'h00 : bus.data_in[{bi, 3'b000} +: 8];
         if (lane_on && is_read) data_out_d[{bi, 3'b000} +: 8] = rdata[8*l +: 8];
      end
   end

   latch_byte_bank #(
      .RAM_BYTES  (RAM_BYTES),
      .ADDR_BITS  (ADDR_BITS),
      .LANE_BYTES (LANE_BYTES)
   ) u_bank (
      .clk     (clk),
      .base_i  (base),
      .we_i    (we),
      .wdata_i (wdata),
      .rdata_o (rdata)
   );

   // Controller state, beat counter and registered read data / completion pulse
   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef LATCH_RAM_ZERO_INIT_EN
         state_q <= INIT;
`else
         state_q <= IDLE;
`endif
         k_q        <= '0;
         data_out_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         ready_q    <= exec && last;
         case (state_q)
`ifdef LATCH_RAM_ZERO_INIT_EN
            INIT: begin
               k_q <= k_q + ADDR_BITS'(1);
               if (k_q == ADDR_BITS'(INIT_LAST)) begin
                  k_q     <= '0;
                  state_q <= IDLE;
               end
            end
`endif
            IDLE, BEAT: begin
               if (txn_n == NO_TXN || last) k_q <= '0;
               else k_q <= k_q + ADDR_BITS'(1);
               state_q <= txn_n == NO_TXN ? IDLE : last ? DONE : BEAT;
            end
            default: if (txn_n == NO_TXN) state_q <= IDLE;
         endcase
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_ready = ready_q;
   assign bus.busy       = state_q != IDLE || (exec && !last);
endmodule

// File: tb/tb_latch_ram_ctrl.sv
// tb_latch_ram_ctrl: LANE_BYTES = 1, 2 and 4 instances driven in lockstep and checked against a byte-array model
module tb_latch_ram_ctrl;
   import latch_ram_pkg::*;
   localparam int NU = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  addr = '0;
   logic [31:0] din = '0;
   logic [1:0]  wn = 2'b11, rn = 2'b11;
   int          n_cmp = 0, n_fail = 0;
   logic [7:0]  mem [NU][64];
   logic [31:0] dout [NU];
   logic        rdy [NU], bsy [NU];

   always #5 clk = ~clk;

   for (genvar u = 0; u < NU; u++) begin : g_dut
      latch_ram_ctrl_if #(.ADDR_BITS(6)) bus ();
      assign bus.addr_in      = addr;
      assign bus.data_in      = din;
      assign bus.data_write_n = wn;
      assign bus.data_read_n  = rn;
      assign dout[u]          = bus.data_out;
      assign rdy[u]           = bus.data_ready;
      assign bsy[u]           = bus.busy;
      latch_ram_ctrl #(.RAM_BYTES(64), .ADDR_BITS(6), .LANE_BYTES(1 << u)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   function automatic int beats(input int n, input int u);
      return (n + (1 << u) - 1) / (1 << u);
   endfunction

   task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s lane%0d: observed %h expected %h", tag, 1 << u, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      n_cmp++;
      assert (rn == 2'b11 || wn == 2'b11) else begin
         n_fail++;
         $error("FAIL proto: observed read_n %b write_n %b expected one idle", rn, wn);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      wn  = 2'b11;
      rn  = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < NU; u++) begin
         chk("rst_dout", u, dout[u], 32'h0);
         chk("rst_ready", u, 32'(rdy[u]), 32'h0);
`ifdef LATCH_RAM_ZERO_INIT_EN
         chk("rst_busy", u, 32'(bsy[u]), 32'h1);
`else
         chk("rst_busy", u, 32'(bsy[u]), 32'h0);
`endif
      end
      rst = 1'b0;
`ifdef LATCH_RAM_ZERO_INIT_EN
      for (int u = 0; u < NU; u++)
         for (int i = 0; i < 64; i++) mem[u][i] = 8'h00;
      repeat (64) @(posedge clk);
      #1;
      for (int u = 0; u < NU; u++) chk("init_end_busy", u, 32'(bsy[u]), 32'h0);
`endif
   endtask

   // Issue one request, hold it for `hold` cycles, then release and let every instance settle
   task automatic txn(input bit wr, input logic [1:0] c, input logic [5:0] a, input logic [31:0] d,
                      input int hold, input bit zero_after = 1'b0);
      int n;
      int rc [NU];
      int rat [NU];
      logic [31:0] rdv [NU];
      logic [31:0] exp;
      n    = 1 << c;
      addr = a;
      din  = d;
      if (wr) wn = c;
      else rn = c;
      #1;
      for (int u = 0; u < NU; u++) begin
         chk("busy_start", u, 32'(bsy[u]), 32'(beats(n, u) > 1));
         rc[u]  = 0;
         rat[u] = 0;
         rdv[u] = '0;
      end
      for (int cyc = 1; cyc <= hold + 2; cyc++) begin
         @(posedge clk);
         #1;
         for (int u = 0; u < NU; u++) begin
            if (rdy[u]) begin
               rc[u]++;
               rat[u] = cyc;
               rdv[u] = dout[u];
            end
            if (cyc == 1) chk("busy_run", u, 32'(bsy[u]), 32'h1);
         end
         if (zero_after && cyc == 4) din = '0;
         if (cyc == hold) begin
            wn = 2'b11;
            rn = 2'b11;
         end
      end
      for (int u = 0; u < NU; u++) begin
         chk("ready_count", u, 32'(rc[u]), 32'(hold >= beats(n, u)));
         chk("busy_end", u, 32'(bsy[u]), 32'h0);
         if (hold >= beats(n, u)) chk("ready_cycle", u, 32'(rat[u]), 32'(beats(n, u)));
         if (wr) begin
            for (int j = 0; j < n && j < hold * (1 << u); j++) mem[u][6'(int'(a) + j)] = d[8*j +: 8];
         end else if (hold >= beats(n, u)) begin
            exp = '0;
            for (int j = 0; j < n; j++) exp[8*j +: 8] = mem[u][6'(int'(a) + j)];
            chk("rdata", u, rdv[u], exp);
            chk("rdata_hold", u, dout[u], exp);
         end
      end
   endtask

   initial begin
`ifdef LATCH_RAM_ZERO_INIT_EN
      begin
         int lowc [NU];
         int first [NU];
         int rc [NU];
         logic [31:0] v [NU];
         rst  = 1'b1;
         addr = 6'h20;
         rn   = SIZE_16;
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b0;
         for (int u = 0; u < NU; u++) begin
            lowc[u]  = 0;
            first[u] = -1;
            rc[u]    = 0;
            v[u]     = 'x;
         end
         for (int cyc = 0; cyc <= 70; cyc++) begin
            for (int u = 0; u < NU; u++) begin
               if (cyc < (64 >> u) && !bsy[u]) lowc[u]++;
               if (rdy[u]) begin
                  rc[u]++;
                  if (first[u] < 0) begin
                     first[u] = cyc;
                     v[u]     = dout[u];
                  end
               end
            end
            @(posedge clk);
            #1;
         end
         rn = 2'b11;
         repeat (2) @(posedge clk);
         #1;
         for (int u = 0; u < NU; u++) begin
            chk("init_busy_low", u, 32'(lowc[u]), 32'h0);
            chk("init_ready_cycle", u, 32'(first[u]), 32'((64 >> u) + beats(2, u)));
            chk("init_read_zero", u, v[u], 32'h0);
            chk("init_ready_count", u, 32'(rc[u]), 32'h1);
            for (int i = 0; i < 64; i++) mem[u][i] = 8'h00;
         end
      end
`endif
      do_reset();
      for (int i = 0; i < 16; i++) txn(1'b1, SIZE_32, 6'(4 * i), $urandom, 5);
      txn(1'b1, SIZE_32, 6'h04, 32'hDEADBEEF, 5);
      txn(1'b0, SIZE_32, 6'h04, 32'h0, 5);
      txn(1'b1, SIZE_8, 6'h06, 32'h000000A5, 5);
      txn(1'b0, SIZE_32, 6'h04, 32'h0, 5);
      txn(1'b1, SIZE_32, 6'h3E, 32'h11223344, 5);
      txn(1'b0, SIZE_32, 6'h3E, 32'h0, 5);
      txn(1'b0, SIZE_8, 6'h00, 32'h0, 5);
      txn(1'b0, SIZE_8, 6'h01, 32'h0, 5);
      txn(1'b0, SIZE_16, 6'h3F, 32'h0, 5);
      txn(1'b1, SIZE_32, 6'h08, 32'h55AA1234, 9, 1'b1);
      txn(1'b0, SIZE_32, 6'h08, 32'h0, 5);
      txn(1'b1, SIZE_32, 6'h10, 32'hCAFEF00D, 2);
      txn(1'b0, SIZE_32, 6'h10, 32'h0, 5);
      addr = 6'h20;
      din  = 32'h89ABCDEF;
      wn   = SIZE_32;
      @(posedge clk);
      #1;
      for (int u = 0; u < NU; u++)
         for (int j = 0; j < 4 && j < (1 << u); j++) mem[u][6'(32 + j)] = din[8*j +: 8];
      do_reset();
      txn(1'b0, SIZE_32, 6'h20, 32'h0, 5);
      txn(1'b0, SIZE_32, 6'h10, 32'h0, 5);
      for (int i = 0; i < 40; i++)
         txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 6'($urandom), $urandom,
             $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : $urandom_range(4, 6));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
